uart_cmd_frame_ctrl: RTL and testbench

- Sits downstream of the UART receive byte buffer, which releases received bytes in bursts after a line-idle gap.
- Parses that byte stream into command frames: HEAD, ADDR, LEN, LEN payload bytes, CHK.
- Holds each payload in a local buffer and commits it as register writes on a valid/ready bus only when the checksum passes.
- Configures downstream blocks; corrupt, truncated or malformed frames never produce writes.

---
 rtl/uart_cmd_pkg.sv | 16 +
 rtl/cmd_payload_buf.sv | 23 ++
 rtl/uart_cmd_frame_ctrl.sv | 216 +++++++++++++++++++++
 tb/tb_uart_cmd_frame_ctrl.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_cmd_pkg.sv
// Shared types and constants for the UART command frame controller.
package uart_cmd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ADDR  = 3'd1,
    ST_LEN   = 3'd2,
    ST_DATA  = 3'd3,
    ST_CHK   = 3'd4,
    ST_DRAIN = 3'd5
  } state_t;

  localparam logic [7:0] DEF_HEAD = 8'h55;
  localparam int         CHK_W    = 8;

endpackage

// File: rtl/cmd_payload_buf.sv
// Payload staging buffer: one synchronous write port, one combinational read port.
module cmd_payload_buf #(
  parameter int P_DEPTH = 16,
  parameter int P_IDX_W = (P_DEPTH > 1) ? $clog2(P_DEPTH) : 1
) (
  input  logic               i_clk,
  input  logic               wr_en,
  input  logic [P_IDX_W-1:0] wr_idx,
  input  logic [7:0]         wr_data,
  input  logic [P_IDX_W-1:0] rd_idx,
  output logic [7:0]         rd_data
);

  logic [7:0] mem [P_DEPTH];

  always_ff @(posedge i_clk) begin
    if (wr_en) mem[wr_idx] <= wr_data;
  end

  // Look-ahead reads past the last beat fall outside the array; return zero.
  assign rd_data = (int'(rd_idx) < P_DEPTH) ? mem[rd_idx] : 8'h00;

endmodule

// File: rtl/uart_cmd_frame_ctrl.sv
// Parses HEAD/ADDR/LEN/payload/CHK frames from the UART byte stream and
// commits checksum-verified payloads as register writes on a valid/ready bus.
module uart_cmd_frame_ctrl
  import uart_cmd_pkg::*;
#(
  parameter logic [7:0] P_HEAD    = DEF_HEAD,
  parameter int         P_MAX_LEN = 16,
  parameter int         P_TIMEOUT = 1000
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [7:0] i_rx_data,
  input  logic       i_rx_valid,
  output logic [7:0] o_wr_addr,
  output logic [7:0] o_wr_data,
  output logic       o_wr_valid,
  input  logic       i_wr_ready,
  output logic       o_busy,
  output logic       o_frame_ok,
  output logic       o_err_chk,
  output logic       o_err_len,
  output logic       o_err_tout,
  output logic       o_err_busy
);

  localparam int IDX_W = (P_MAX_LEN > 1) ? $clog2(P_MAX_LEN) : 1;
  localparam int CNT_W = $clog2(P_TIMEOUT);
  localparam logic [CNT_W-1:0] TOUT_LAST = CNT_W'(P_TIMEOUT - 1);
  localparam logic [7:0]       MAX_LEN_B = 8'(P_MAX_LEN);

  state_t             state_reg, state_next;
  logic [CHK_W-1:0]   sum_reg, sum_next;
  logic [CNT_W-1:0]   tout_reg, tout_next;
  logic [7:0]         data_idx_reg, data_idx_next;
  logic [7:0]         drain_idx_reg, drain_idx_next;
  logic [7:0]         base_addr_reg, base_addr_next;
  logic [7:0]         len_reg, len_next;
  logic [7:0]         wr_addr_reg, wr_addr_next;
  logic [7:0]         wr_data_reg, wr_data_next;
  logic               wr_valid_reg, wr_valid_next;
  logic               busy_reg;
  logic               ok_reg, ok_next;
  logic               err_chk_reg, err_chk_next;
  logic               err_len_reg, err_len_next;
  logic               err_tout_reg, err_tout_next;
  logic               err_busy_reg, err_busy_next;

  logic               buf_wr_en;
  logic [IDX_W-1:0]   buf_rd_idx;
  logic [7:0]         buf_rd_data;
  logic [7:0]         drain_idx_inc;

  assign drain_idx_inc = drain_idx_reg + 8'd1;

  cmd_payload_buf #(
    .P_DEPTH (P_MAX_LEN),
    .P_IDX_W (IDX_W)
  ) u_buf (
    .i_clk   (i_clk),
    .wr_en   (buf_wr_en),
    .wr_idx  (data_idx_reg[IDX_W-1:0]),
    .wr_data (i_rx_data),
    .rd_idx  (buf_rd_idx),
    .rd_data (buf_rd_data)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_reg     <= ST_IDLE;
      sum_reg       <= '0;
      tout_reg      <= '0;
      data_idx_reg  <= '0;
      drain_idx_reg <= '0;
      base_addr_reg <= '0;
      len_reg       <= '0;
      wr_addr_reg   <= '0;
      wr_data_reg   <= '0;
      wr_valid_reg  <= 1'b0;
      busy_reg      <= 1'b0;
      ok_reg        <= 1'b0;
      err_chk_reg   <= 1'b0;
      err_len_reg   <= 1'b0;
      err_tout_reg  <= 1'b0;
      err_busy_reg  <= 1'b0;
    end else begin
      state_reg     <= state_next;
      sum_reg       <= sum_next;
      tout_reg      <= tout_next;
      data_idx_reg  <= data_idx_next;
      drain_idx_reg <= drain_idx_next;
      base_addr_reg <= base_addr_next;
      len_reg       <= len_next;
      wr_addr_reg   <= wr_addr_next;
      wr_data_reg   <= wr_data_next;
      wr_valid_reg  <= wr_valid_next;
      busy_reg      <= (state_next != ST_IDLE);
      ok_reg        <= ok_next;
      err_chk_reg   <= err_chk_next;
      err_len_reg   <= err_len_next;
      err_tout_reg  <= err_tout_next;
      err_busy_reg  <= err_busy_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    sum_next       = sum_reg;
    tout_next      = tout_reg;
    data_idx_next  = data_idx_reg;
    drain_idx_next = drain_idx_reg;
    base_addr_next = base_addr_reg;
    len_next       = len_reg;
    wr_addr_next   = wr_addr_reg;
    wr_data_next   = wr_data_reg;
    wr_valid_next  = wr_valid_reg;
    ok_next        = 1'b0;
    err_chk_next   = 1'b0;
    err_len_next   = 1'b0;
    err_tout_next  = 1'b0;
    err_busy_next  = 1'b0;
    buf_wr_en      = 1'b0;
    buf_rd_idx     = '0;

    // Inter-byte watchdog; a byte arriving on the expiry cycle takes priority.
    if (state_reg inside {ST_ADDR, ST_LEN, ST_DATA, ST_CHK}) begin
      if (i_rx_valid) begin
        tout_next = '0;
      end else if (tout_reg == TOUT_LAST) begin
        tout_next     = '0;
        state_next    = ST_IDLE;
        err_tout_next = 1'b1;
      end else begin
        tout_next = tout_reg + 1'b1;
      end
    end

    case (state_reg)
      ST_IDLE: begin
        if (i_rx_valid && i_rx_data == P_HEAD) begin
          state_next    = ST_ADDR;
          sum_next      = '0;
          tout_next     = '0;
          data_idx_next = '0;
        end
      end
      ST_ADDR: begin
        if (i_rx_valid) begin
          base_addr_next = i_rx_data;
          sum_next       = sum_reg + i_rx_data;
          state_next     = ST_LEN;
        end
      end
      ST_LEN: begin
        if (i_rx_valid) begin
          if (i_rx_data == 8'd0 || i_rx_data > MAX_LEN_B) begin
            err_len_next = 1'b1;
            state_next   = ST_IDLE;
          end else begin
            len_next   = i_rx_data;
            sum_next   = sum_reg + i_rx_data;
            state_next = ST_DATA;
          end
        end
      end
      ST_DATA: begin
        if (i_rx_valid) begin
          buf_wr_en = 1'b1;
          sum_next  = sum_reg + i_rx_data;
          if (data_idx_reg == len_reg - 8'd1) state_next = ST_CHK;
          else data_idx_next = data_idx_reg + 8'd1;
        end
      end
      ST_CHK: begin
        if (i_rx_valid) begin
          if (i_rx_data == sum_reg) begin
            ok_next        = 1'b1;
            state_next     = ST_DRAIN;
            drain_idx_next = '0;
            wr_valid_next  = 1'b1;
            wr_addr_next   = base_addr_reg;
            wr_data_next   = buf_rd_data;
          end else begin
            err_chk_next = 1'b1;
            state_next   = ST_IDLE;
          end
        end
      end
      ST_DRAIN: begin
        err_busy_next = i_rx_valid;
        buf_rd_idx    = drain_idx_inc[IDX_W-1:0];
        if (wr_valid_reg && i_wr_ready) begin
          if (drain_idx_reg == len_reg - 8'd1) begin
            wr_valid_next = 1'b0;
            state_next    = ST_IDLE;
          end else begin
            drain_idx_next = drain_idx_inc;
            wr_addr_next   = wr_addr_reg + 8'd1;
            wr_data_next   = buf_rd_data;
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign o_wr_addr  = wr_addr_reg;
  assign o_wr_data  = wr_data_reg;
  assign o_wr_valid = wr_valid_reg;
  assign o_busy     = busy_reg;
  assign o_frame_ok = ok_reg;
  assign o_err_chk  = err_chk_reg;
  assign o_err_len  = err_len_reg;
  assign o_err_tout = err_tout_reg;
  assign o_err_busy = err_busy_reg;

endmodule

// File: tb/tb_uart_cmd_frame_ctrl.sv
// Directed frame vectors plus hand-written timeout, backpressure and reset sequences.
module tb_uart_cmd_frame_ctrl;

  logic       clk;
  logic       rst_n;
  logic [7:0] i_rx_data;
  logic       i_rx_valid;
  logic [7:0] o_wr_addr;
  logic [7:0] o_wr_data;
  logic       o_wr_valid;
  logic       i_wr_ready;
  logic       o_busy;
  logic       o_frame_ok;
  logic       o_err_chk;
  logic       o_err_len;
  logic       o_err_tout;
  logic       o_err_busy;

  uart_cmd_frame_ctrl dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_rx_data  (i_rx_data),
    .i_rx_valid (i_rx_valid),
    .o_wr_addr  (o_wr_addr),
    .o_wr_data  (o_wr_data),
    .o_wr_valid (o_wr_valid),
    .i_wr_ready (i_wr_ready),
    .o_busy     (o_busy),
    .o_frame_ok (o_frame_ok),
    .o_err_chk  (o_err_chk),
    .o_err_len  (o_err_len),
    .o_err_tout (o_err_tout),
    .o_err_busy (o_err_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor on the falling edge: writes accepted and pulses seen.
  int         cyc = 0;
  int         n_ok = 0, n_chk = 0, n_len = 0, n_tout = 0, n_busy = 0, n_multi = 0;
  logic [7:0] wq_a[$];
  logic [7:0] wq_d[$];
  int         wq_c[$];

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (o_wr_valid && i_wr_ready) begin
      wq_a.push_back(o_wr_addr);
      wq_d.push_back(o_wr_data);
      wq_c.push_back(cyc);
    end
    if (o_frame_ok) n_ok = n_ok + 1;
    if (o_err_chk)  n_chk = n_chk + 1;
    if (o_err_len)  n_len = n_len + 1;
    if (o_err_tout) n_tout = n_tout + 1;
    if (o_err_busy) n_busy = n_busy + 1;
    if (int'(o_err_chk) + int'(o_err_len) + int'(o_err_tout) + int'(o_err_busy) > 1)
      n_multi = n_multi + 1;
  end

  typedef struct {
    logic [0:9][7:0] b;
    int              n;
    int              ok;
    int              chk;
    int              len;
    int              nwr;
    logic [0:3][7:0] wa;
    logic [0:3][7:0] wd;
  } vec_t;

  vec_t vecs[7];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    i_rx_data  = b;
    i_rx_valid = 1'b1;
    tick();
    i_rx_valid = 1'b0;
  endtask

  task automatic run_vector(input int i);
    int ok0, chk0, len0, tout0, busy0, w0;
    ok0 = n_ok; chk0 = n_chk; len0 = n_len; tout0 = n_tout; busy0 = n_busy; w0 = wq_a.size();
    i_wr_ready = 1'b1;
    for (int k = 0; k < vecs[i].n; k++) send_byte(vecs[i].b[k]);
    repeat (8) tick();
    $display("vec %0d: ok=%0d chk=%0d len=%0d writes=%0d busy=%0b", i,
             n_ok - ok0, n_chk - chk0, n_len - len0, wq_a.size() - w0, o_busy);
    check($sformatf("vec%0d_ok", i),   n_ok - ok0,   vecs[i].ok);
    check($sformatf("vec%0d_chk", i),  n_chk - chk0, vecs[i].chk);
    check($sformatf("vec%0d_len", i),  n_len - len0, vecs[i].len);
    check($sformatf("vec%0d_tout", i), n_tout - tout0, 0);
    check($sformatf("vec%0d_ebusy", i), n_busy - busy0, 0);
    check($sformatf("vec%0d_nwr", i),  wq_a.size() - w0, vecs[i].nwr);
    check($sformatf("vec%0d_busy", i), o_busy, 0);
    if (wq_a.size() - w0 == vecs[i].nwr) begin
      for (int k = 0; k < vecs[i].nwr; k++) begin
        check($sformatf("vec%0d_wa%0d", i, k), wq_a[w0+k], vecs[i].wa[k]);
        check($sformatf("vec%0d_wd%0d", i, k), wq_d[w0+k], vecs[i].wd[k]);
        if (k > 0) check($sformatf("vec%0d_gap%0d", i, k), wq_c[w0+k] - wq_c[w0+k-1], 1);
      end
    end
  endtask

  initial begin
    int ok0, tout0, busy0, w0;
    logic [7:0] ea;
    logic [7:0] bp_data [3];

    vecs[0] = '{{8'h55,8'h10,8'h03,8'hAA,8'hBB,8'hCC,8'h44,8'h00,8'h00,8'h00}, 7, 1, 0, 0, 3,
                {8'h10,8'h11,8'h12,8'h00}, {8'hAA,8'hBB,8'hCC,8'h00}};
    vecs[1] = '{{8'h55,8'h10,8'h03,8'hAA,8'hBB,8'hCC,8'h47,8'h00,8'h00,8'h00}, 7, 0, 1, 0, 0,
                {8'h00,8'h00,8'h00,8'h00}, {8'h00,8'h00,8'h00,8'h00}};
    vecs[2] = '{{8'h00,8'h13,8'h55,8'h10,8'h03,8'hAA,8'hBB,8'hCC,8'h44,8'h00}, 9, 1, 0, 0, 3,
                {8'h10,8'h11,8'h12,8'h00}, {8'hAA,8'hBB,8'hCC,8'h00}};
    vecs[3] = '{{8'h55,8'h20,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00}, 3, 0, 0, 1, 0,
                {8'h00,8'h00,8'h00,8'h00}, {8'h00,8'h00,8'h00,8'h00}};
    vecs[4] = '{{8'h55,8'h20,8'h11,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00}, 3, 0, 0, 1, 0,
                {8'h00,8'h00,8'h00,8'h00}, {8'h00,8'h00,8'h00,8'h00}};
    vecs[5] = '{{8'h55,8'h30,8'h01,8'h7E,8'hAF,8'h00,8'h00,8'h00,8'h00,8'h00}, 5, 1, 0, 0, 1,
                {8'h30,8'h00,8'h00,8'h00}, {8'h7E,8'h00,8'h00,8'h00}};
    vecs[6] = '{{8'h55,8'h55,8'h02,8'h55,8'h01,8'hAD,8'h00,8'h00,8'h00,8'h00}, 6, 1, 0, 0, 2,
                {8'h55,8'h56,8'h00,8'h00}, {8'h55,8'h01,8'h00,8'h00}};

    rst_n      = 1'b0;
    i_rx_data  = 8'h00;
    i_rx_valid = 1'b0;
    i_wr_ready = 1'b0;
    repeat (3) tick();
    check("rst_wr_valid", o_wr_valid, 0);
    check("rst_busy",     o_busy, 0);
    check("rst_outs", {o_frame_ok, o_err_chk, o_err_len, o_err_tout, o_err_busy}, 0);
    check("rst_addr_data", {o_wr_addr, o_wr_data}, 0);
    rst_n = 1'b1;
    repeat (2) tick();

    for (int i = 0; i < 7; i++) run_vector(i);

    // Timeout: the 1000th idle cycle after a byte expires the frame.
    tout0 = n_tout; w0 = wq_a.size();
    send_byte(8'h55); send_byte(8'h20); send_byte(8'h02); send_byte(8'hAA);
    repeat (999) tick();
    check("tout_not_yet", n_tout - tout0, 0);
    check("tout_busy_before", o_busy, 1);
    repeat (3) tick();
    $display("timeout: pulses=%0d busy=%0b", n_tout - tout0, o_busy);
    check("tout_once", n_tout - tout0, 1);
    check("tout_busy_after", o_busy, 0);
    check("tout_no_wr", wq_a.size() - w0, 0);

    // A byte on the expiry cycle wins and the frame completes.
    tout0 = n_tout; ok0 = n_ok; w0 = wq_a.size();
    i_wr_ready = 1'b1;
    send_byte(8'h55); send_byte(8'h20); send_byte(8'h02); send_byte(8'hAA);
    repeat (999) tick();
    send_byte(8'hBB);
    send_byte(8'h87);
    repeat (6) tick();
    $display("late byte: tout=%0d ok=%0d writes=%0d", n_tout - tout0, n_ok - ok0, wq_a.size() - w0);
    check("late_no_tout", n_tout - tout0, 0);
    check("late_ok", n_ok - ok0, 1);
    check("late_nwr", wq_a.size() - w0, 2);
    if (wq_a.size() - w0 == 2) begin
      check("late_wa1", wq_a[w0+1], 8'h21);
      check("late_wd1", wq_d[w0+1], 8'hBB);
    end

    // Backpressure, address wrap and bytes dropped during drain.
    bp_data[0] = 8'h11; bp_data[1] = 8'h22; bp_data[2] = 8'h33;
    ok0 = n_ok; busy0 = n_busy; w0 = wq_a.size();
    i_wr_ready = 1'b0;
    send_byte(8'h55); send_byte(8'hFE); send_byte(8'h03);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h67);
    for (int b = 0; b < 3; b++) begin
      ea = 8'hFE + 8'(b);
      check($sformatf("bp_valid%0d", b), o_wr_valid, 1);
      check($sformatf("bp_addr%0d", b), o_wr_addr, ea);
      check($sformatf("bp_data%0d", b), o_wr_data, bp_data[b]);
      if (b < 2) begin i_rx_valid = 1'b1; i_rx_data = 8'h55; end
      tick();
      i_rx_valid = 1'b0;
      $display("bp beat %0d stalled: addr=%0h data=%0h", b, o_wr_addr, o_wr_data);
      check($sformatf("bp_hold_addr%0d", b), o_wr_addr, ea);
      check($sformatf("bp_hold_data%0d", b), o_wr_data, bp_data[b]);
      i_wr_ready = 1'b1;
      if (b == 2) begin i_rx_valid = 1'b1; i_rx_data = 8'h55; end
      tick();
      i_rx_valid = 1'b0;
      i_wr_ready = 1'b0;
    end
    check("bp_valid_end", o_wr_valid, 0);
    repeat (3) tick();
    $display("backpressure: writes=%0d err_busy=%0d busy=%0b", wq_a.size() - w0, n_busy - busy0, o_busy);
    check("bp_err_busy", n_busy - busy0, 3);
    check("bp_ok", n_ok - ok0, 1);
    check("bp_idle_after", o_busy, 0);
    check("bp_nwr", wq_a.size() - w0, 3);
    if (wq_a.size() - w0 == 3) begin
      check("bp_wq_a2", wq_a[w0+2], 8'h00);
      check("bp_wq_d2", wq_d[w0+2], 8'h33);
    end

    // Reset during the third drain beat.
    w0 = wq_a.size();
    i_wr_ready = 1'b1;
    send_byte(8'h55); send_byte(8'h40); send_byte(8'h03);
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h49);
    tick();
    tick();
    check("rd_beat2_addr", o_wr_addr, 8'h42);
    check("rd_beat2_data", o_wr_data, 8'h03);
    #1 rst_n = 1'b0;
    #1;
    $display("reset mid-drain: wr_valid=%0b busy=%0b", o_wr_valid, o_busy);
    check("rd_valid_async", o_wr_valid, 0);
    check("rd_busy_async", o_busy, 0);
    i_wr_ready = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (2) tick();
    check("rd_busy_after", o_busy, 0);
    check("rd_partial_nwr", wq_a.size() - w0, 2);
    run_vector(0);

    check("pulse_exclusive", n_multi, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
